esm_dep_scoreboard: RTL and testbench

Parametrised instruction-dependency scoreboard for the ESM front end. It tracks up to BS in-flight instructions with a register last-writer table and a BS x BS dependency matrix. Each row is the consumer slot; each column is a producer slot. Unlike the earlier dependency-analysis core, it allocates slots itself, clears dependencies on completion, and issues ready instructions through a valid/ready handshake. It sits between decode and the execution buffer.

---
 rtl/esm_pkg.sv | 35 +++
 rtl/esm_prio_pick.sv | 20 ++
 rtl/esm_dep_scoreboard.sv | 152 +++++++++++++++
 tb/tb_esm_dep_scoreboard.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared types and constants for the ESM dependency scoreboard.
// Field positions follow the RV32 R-type layout.
package esm_pkg;

  localparam int ESM_REGNUM = 32;
  localparam int ESM_BS     = 16;
  localparam int REG_ADDR_W = $clog2(ESM_REGNUM);
  localparam int SLOT_W     = $clog2(ESM_BS);

  typedef logic [SLOT_W-1:0]     slot_idx_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

  typedef struct packed {
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      use_rs2;
    logic      reg_write;
  } dec_fields_t;

  function automatic dec_fields_t decode(input logic [24:0] instr,
                                         input logic        use_rs2,
                                         input logic        reg_write);
    dec_fields_t f;
    f.rs1       = instr[19:15];
    f.rs2       = instr[24:20];
    f.rd        = instr[11:7];
    f.use_rs2   = use_rs2;
    f.reg_write = reg_write;
    return f;
  endfunction

endpackage

// File: rtl/esm_prio_pick.sv
// Lowest-set-bit picker: returns the index of the lowest request and whether
// any request is set. The index reads 0 when no request is set.
module esm_prio_pick #(
  parameter int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/esm_dep_scoreboard.sv
// Instruction-dependency scoreboard: slot allocation, last-writer table,
// dependency matrix and issue selection. ESM_AGE_ORDER_EN selects oldest-ready issue.
module esm_dep_scoreboard
  import esm_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int REGNUM  = 32,
  parameter int BS      = 16,
  localparam int IDX_W  = $clog2(BS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               use_rs2,
  input  logic               reg_write,
  output logic [IDX_W-1:0]   alloc_index,
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [IDX_W-1:0]   issue_index,
  input  logic               complete_valid,
  input  logic [IDX_W-1:0]   complete_index,
  output logic [IDX_W:0]     occupancy,
  output logic               full,
  output logic               empty
);

  logic [BS-1:0]                valid_q, valid_d;
  logic [BS-1:0]                issued_q, issued_d;
  logic [BS-1:0][BS-1:0]        dep_q, dep_d;
  logic [REGNUM-1:0]            wvalid_q, wvalid_d;
  logic [REGNUM-1:0][IDX_W-1:0] wslot_q, wslot_d;

  dec_fields_t   dec;
  logic [BS-1:0] ready;
  logic [BS-1:0] pick_req;
  logic [BS-1:0] new_row;
  logic          alloc_any;
  logic          do_alloc, do_issue, comp_ok;
  logic          unused_bits;

  assign dec         = decode(instr_in[24:0], use_rs2, reg_write);
  assign unused_bits = ^{instr_in[INSTR_W-1:25], instr_in[14:12], instr_in[6:0]};

  esm_prio_pick #(.N(BS)) u_alloc_pick (
    .req_i (~valid_q),
    .idx_o (alloc_index),
    .any_o (alloc_any)
  );

  assign full     = &valid_q;
  assign empty    = ~|valid_q;
  assign in_ready = alloc_any;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < BS; i++) occupancy = occupancy + (IDX_W+1)'(valid_q[i]);
  end

  always_comb begin
    for (int i = 0; i < BS; i++) ready[i] = valid_q[i] && !issued_q[i] && (dep_q[i] == '0);
  end

`ifdef ESM_AGE_ORDER_EN
  // age_q[i][j] set means slot i was allocated before slot j.
  logic [BS-1:0][BS-1:0] age_q, age_d;

  always_comb begin
    for (int i = 0; i < BS; i++) begin
      pick_req[i] = ready[i];
      for (int j = 0; j < BS; j++) begin
        if (ready[j] && age_q[j][i]) pick_req[i] = 1'b0;
      end
    end
  end

  always_comb begin
    age_d = age_q;
    if (do_alloc) begin
      age_d[alloc_index] = '0;
      for (int j = 0; j < BS; j++) age_d[j][alloc_index] = valid_q[j];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) age_q <= '0;
    else      age_q <= age_d;
  end
`else
  assign pick_req = ready;
`endif

  esm_prio_pick #(.N(BS)) u_issue_pick (
    .req_i (pick_req),
    .idx_o (issue_index),
    .any_o (issue_valid)
  );

  assign do_alloc = in_valid && in_ready;
  assign do_issue = issue_valid && issue_ready;
  assign comp_ok  = complete_valid && valid_q[complete_index] && issued_q[complete_index];

  // Allocation reads the pre-update table so rd==rs1 depends on the older writer;
  // a producer completing this cycle is bypassed, and a new rd overrides the clear.
  always_comb begin
    valid_d  = valid_q;
    issued_d = issued_q;
    dep_d    = dep_q;
    wvalid_d = wvalid_q;
    wslot_d  = wslot_q;
    new_row  = '0;
    if (comp_ok) begin
      valid_d[complete_index]  = 1'b0;
      issued_d[complete_index] = 1'b0;
      for (int i = 0; i < BS; i++) dep_d[i][complete_index] = 1'b0;
      for (int r = 0; r < REGNUM; r++) begin
        if (wvalid_q[r] && wslot_q[r] == complete_index) wvalid_d[r] = 1'b0;
      end
    end
    if (do_issue) issued_d[issue_index] = 1'b1;
    if (do_alloc) begin
      if (dec.rs1 != ZERO_REG && wvalid_q[dec.rs1]) new_row[wslot_q[dec.rs1]] = 1'b1;
      if (dec.use_rs2 && dec.rs2 != ZERO_REG && wvalid_q[dec.rs2]) new_row[wslot_q[dec.rs2]] = 1'b1;
      if (comp_ok) new_row[complete_index] = 1'b0;
      valid_d[alloc_index]  = 1'b1;
      issued_d[alloc_index] = 1'b0;
      dep_d[alloc_index]    = new_row;
      if (dec.reg_write && dec.rd != ZERO_REG) begin
        wvalid_d[dec.rd] = 1'b1;
        wslot_d[dec.rd]  = alloc_index;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      issued_q <= '0;
      dep_q    <= '0;
      wvalid_q <= '0;
      wslot_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      issued_q <= issued_d;
      dep_q    <= dep_d;
      wvalid_q <= wvalid_d;
      wslot_q  <= wslot_d;
    end
  end

endmodule

// File: tb/tb_esm_dep_scoreboard.sv
// Self-checking bench for esm_dep_scoreboard; issue order is tracked through
// an expected-index queue. Honours ESM_AGE_ORDER_EN for the age-order scenario.
module tb_esm_dep_scoreboard;

  localparam int BS = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   instr_in;
  logic          use_rs2;
  logic          reg_write;
  logic [IW-1:0] alloc_index;
  logic          issue_valid;
  logic          issue_ready;
  logic [IW-1:0] issue_index;
  logic          complete_valid;
  logic [IW-1:0] complete_index;
  logic [IW:0]   occupancy;
  logic          full;
  logic          empty;

  int total = 0;
  int bad   = 0;
  logic [IW-1:0] exp_q[$];

  esm_dep_scoreboard #(.INSTR_W(32), .REGNUM(32), .BS(BS)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .instr_in       (instr_in),
    .use_rs2        (use_rs2),
    .reg_write      (reg_write),
    .alloc_index    (alloc_index),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_index    (issue_index),
    .complete_valid (complete_valid),
    .complete_index (complete_index),
    .occupancy      (occupancy),
    .full           (full),
    .empty          (empty)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    in_valid = 1'b0; instr_in = '0; use_rs2 = 1'b0; reg_write = 1'b0;
    issue_ready = 1'b0; complete_valid = 1'b0; complete_index = '0;
    exp_q.delete();
    tick();
    rst = 1'b1;
  endtask

  // driver tasks
  function automatic logic [31:0] enc(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  task automatic do_alloc(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u2, input logic wr, output logic [IW-1:0] idx);
    in_valid = 1'b1; instr_in = enc(rd, rs1, rs2); use_rs2 = u2; reg_write = wr;
    idx = alloc_index;
    tick();
    in_valid = 1'b0; use_rs2 = 1'b0; reg_write = 1'b0;
  endtask

  task automatic do_complete(input logic [IW-1:0] idx);
    complete_valid = 1'b1; complete_index = idx;
    tick();
    complete_valid = 1'b0;
  endtask

  // scoreboard: pop the expected slot and accept one issue
  task automatic issue_one(input string tag);
    logic [IW-1:0] want;
    int waited;
    want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    waited = 0;
    while (issue_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    total++;
    if (issue_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_issue_timeout got issue_valid=%b want=1 (slot %0d)", tag, issue_valid, want);
    end else begin
      if (issue_index !== want) begin
        bad++;
        $display("FAIL %s_issue_order got=%0d want=%0d", tag, issue_index, want);
      end
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0; instr_in = '0; use_rs2 = 1'b0; reg_write = 1'b0;
    issue_ready = 1'b0; complete_valid = 1'b0; complete_index = '0;
    #3;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid got=%b want=0", issue_valid); end
    total++; if (occupancy !== 5'd0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", occupancy); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (alloc_index !== 4'd0) begin bad++; $display("FAIL reset_alloc_index got=%0d want=0", alloc_index); end
    total++; if (issue_index !== 4'd0) begin bad++; $display("FAIL reset_issue_index got=%0d want=0", issue_index); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [IW-1:0] idx;
    apply_reset();
    do_alloc(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, idx);
    total++; if (idx !== 4'd0) begin bad++; $display("FAIL basic_alloc_index got=%0d want=0", idx); end
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL basic_issue_valid got=%b want=1", issue_valid); end
    total++; if (issue_index !== 4'd0) begin bad++; $display("FAIL basic_issue_index got=%0d want=0", issue_index); end
    total++; if (occupancy !== 5'd1) begin bad++; $display("FAIL basic_occupancy got=%0d want=1", occupancy); end
    exp_q.push_back(4'd0);
    issue_one("basic");
    do_complete(4'd0);
    total++; if (empty !== 1'b1 || occupancy !== 5'd0) begin bad++; $display("FAIL basic_drain got occ=%0d empty=%b want occ=0 empty=1", occupancy, empty); end
  endtask

  task automatic test_dependency();
    logic [IW-1:0] idx;
    apply_reset();
    do_alloc(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, idx);
    exp_q.push_back(4'd0);
    issue_one("dep_prod");
    do_alloc(5'd4, 5'd3, 5'd5, 1'b1, 1'b1, idx);
    total++; if (idx !== 4'd1) begin bad++; $display("FAIL dep_alloc_index got=%0d want=1", idx); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL dep_blocked got issue_valid=%b want=0", issue_valid); end
    do_complete(4'd0);
    total++; if (issue_valid !== 1'b1 || issue_index !== 4'd1) begin bad++; $display("FAIL dep_wakeup got valid=%b idx=%0d want valid=1 idx=1", issue_valid, issue_index); end
    exp_q.push_back(4'd1);
    issue_one("dep_cons");
    do_complete(4'd1);
  endtask

  task automatic test_x0_and_rs2();
    logic [IW-1:0] idx;
    apply_reset();
    do_alloc(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, idx);
    do_alloc(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, idx);
    exp_q.push_back(4'd0); exp_q.push_back(4'd1);
    issue_one("x0_writer");
    issue_one("x0_reader");
    do_alloc(5'd7, 5'd1, 5'd2, 1'b1, 1'b1, idx);
    do_alloc(5'd6, 5'd1, 5'd7, 1'b0, 1'b0, idx);
    total++; if (idx !== 4'd3) begin bad++; $display("FAIL rs2_alloc_index got=%0d want=3", idx); end
    exp_q.push_back(4'd2); exp_q.push_back(4'd3);
    issue_one("rs2_writer");
    issue_one("rs2_unused");
    do_alloc(5'd8, 5'd0, 5'd0, 1'b0, 1'b1, idx);
    do_complete(4'd4);
    total++; if (occupancy !== 5'd5) begin bad++; $display("FAIL ignore_unissued got occ=%0d want=5", occupancy); end
    do_complete(4'd9);
    total++; if (occupancy !== 5'd5) begin bad++; $display("FAIL ignore_invalid got occ=%0d want=5", occupancy); end
    exp_q.push_back(4'd4);
    issue_one("ignore_then_issue");
  endtask

  task automatic test_full();
    logic [IW-1:0] idx;
    apply_reset();
    for (int i = 0; i < BS; i++) begin
      do_alloc(5'($urandom_range(10, 31)), 5'd0, 5'd0, 1'b0, 1'b0, idx);
      total++; if (idx !== IW'(i)) begin bad++; $display("FAIL full_fill_index got=%0d want=%0d", idx, i); end
    end
    total++; if (full !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL full_flags got full=%b in_ready=%b want 1/0", full, in_ready); end
    do_alloc(5'd12, 5'd0, 5'd0, 1'b0, 1'b0, idx);
    total++; if (occupancy !== 5'd16) begin bad++; $display("FAIL full_ignore got occ=%0d want=16", occupancy); end
    for (int i = 0; i < BS; i++) exp_q.push_back(IW'(i));
    for (int i = 0; i < BS; i++) issue_one("full_drain");
    do_complete(4'd5);
    total++; if (alloc_index !== 4'd5) begin bad++; $display("FAIL full_free_index got=%0d want=5", alloc_index); end
    total++; if (in_ready !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL full_free_flags got in_ready=%b full=%b want 1/0", in_ready, full); end
    total++; if (occupancy !== 5'd15) begin bad++; $display("FAIL full_free_occ got=%0d want=15", occupancy); end
    // asynchronous reset while occupied
    rst = 1'b0;
    #1;
    total++; if (occupancy !== 5'd0 || empty !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL midreset got occ=%0d empty=%b in_ready=%b want 0/1/1", occupancy, empty, in_ready); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_bypass();
    logic [IW-1:0] idx;
    apply_reset();
    do_alloc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, idx);
    do_alloc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, idx);
    do_alloc(5'd9, 5'd1, 5'd2, 1'b1, 1'b1, idx);
    for (int i = 0; i < 3; i++) exp_q.push_back(IW'(i));
    for (int i = 0; i < 3; i++) issue_one("bypass_setup");
    complete_valid = 1'b1; complete_index = 4'd2;
    do_alloc(5'd9, 5'd9, 5'd0, 1'b0, 1'b1, idx);
    complete_valid = 1'b0;
    total++; if (idx !== 4'd3) begin bad++; $display("FAIL bypass_alloc_index got=%0d want=3", idx); end
    total++; if (occupancy !== 5'd3) begin bad++; $display("FAIL bypass_occupancy got=%0d want=3", occupancy); end
    total++; if (issue_valid !== 1'b1 || issue_index !== 4'd3) begin bad++; $display("FAIL bypass_ready got valid=%b idx=%0d want 1/3", issue_valid, issue_index); end
    do_alloc(5'd10, 5'd9, 5'd0, 1'b0, 1'b1, idx);
    total++; if (idx !== 4'd2) begin bad++; $display("FAIL bypass_reuse_index got=%0d want=2", idx); end
    exp_q.push_back(4'd3);
    issue_one("bypass_new_writer");
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL bypass_table_update got issue_valid=%b want=0", issue_valid); end
    do_complete(4'd3);
    exp_q.push_back(4'd2);
    issue_one("bypass_reader");
  endtask

  task automatic test_age_order();
    logic [IW-1:0] idx;
    apply_reset();
    for (int i = 0; i < 4; i++) do_alloc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, idx);
    for (int i = 0; i < 4; i++) exp_q.push_back(IW'(i));
    for (int i = 0; i < 4; i++) issue_one("age_setup");
    do_complete(4'd3);
    do_alloc(5'd0, 5'd1, 5'd0, 1'b0, 1'b0, idx);
    total++; if (idx !== 4'd3) begin bad++; $display("FAIL age_first_slot got=%0d want=3", idx); end
    do_complete(4'd1);
    do_alloc(5'd0, 5'd2, 5'd0, 1'b0, 1'b0, idx);
    total++; if (idx !== 4'd1) begin bad++; $display("FAIL age_second_slot got=%0d want=1", idx); end
`ifdef ESM_AGE_ORDER_EN
    exp_q.push_back(4'd3); exp_q.push_back(4'd1);
`else
    exp_q.push_back(4'd1); exp_q.push_back(4'd3);
`endif
    issue_one("age_first");
    issue_one("age_second");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dependency();
    test_x0_and_rs2();
    test_full();
    test_bypass();
    test_age_order();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
